// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the dual-bank register file: integer writes win,
// losing FP results queue in a small FIFO, and a busy scoreboard flags FP hazards.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_write,
  input  logic [1:0]  i_fpoint,
  input  logic [4:0]  i_rw,
  input  logic [31:0] i_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rw,
  input  logic        f_valid,
  input  logic [4:0]  f_rw,
  input  logic [31:0] f_data,
  output logic        f_ready,
  input  logic        q_en,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  input  logic [4:0]  q_rd,
  output logic        hazard,
  output logic        rf_write,
  output logic [1:0]  rf_fpoint,
  output logic [4:0]  rf_rd,
  output logic        rf_regdst,
  output logic [31:0] rf_busW
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [4:0]    fifo_rw   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [31:0]   busy, busy_nxt;

  logic       empty, pop, bypass, push, fp_commit;
  logic [4:0] commit_rw;

  assign empty     = (count == '0);
  assign f_ready   = (count != FULL);
  assign pop       = !i_write && !empty;
  assign bypass    = !i_write && empty && f_valid;
  assign push      = f_valid && f_ready && !bypass;
  assign fp_commit = pop || bypass;
  assign commit_rw = pop ? fifo_rw[rptr] : f_rw;
  assign rf_regdst = 1'b1;
  assign hazard    = q_en && (busy[q_rs] || busy[q_rt] || busy[q_rd]);

  always_comb begin
    rf_write  = 1'b0;
    rf_fpoint = 2'd0;
    rf_rd     = 5'd0;
    rf_busW   = 32'd0;
    if (i_write) begin
      rf_write  = 1'b1;
      rf_fpoint = i_fpoint;
      rf_rd     = i_rw;
      rf_busW   = i_data;
    end else if (!empty) begin
      rf_write  = 1'b1;
      rf_fpoint = 2'd3;
      rf_rd     = fifo_rw[rptr];
      rf_busW   = fifo_data[rptr];
    end else if (f_valid) begin
      rf_write  = 1'b1;
      rf_fpoint = 2'd3;
      rf_rd     = f_rw;
      rf_busW   = f_data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (fp_commit) busy_nxt[commit_rw] = 1'b0;
    if (iss_valid) busy_nxt[iss_rw] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      busy  <= '0;
    end else begin
      if (push) begin
        fifo_rw[wptr]   <= f_rw;
        fifo_data[wptr] <= f_data;
        wptr            <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the write port.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_write;
  logic [1:0]  i_fpoint;
  logic [4:0]  i_rw;
  logic [31:0] i_data;
  logic        iss_valid;
  logic [4:0]  iss_rw;
  logic        f_valid;
  logic [4:0]  f_rw;
  logic [31:0] f_data;
  logic        f_ready;
  logic        q_en;
  logic [4:0]  q_rs, q_rt, q_rd;
  logic        hazard;
  logic        rf_write;
  logic [1:0]  rf_fpoint;
  logic [4:0]  rf_rd;
  logic        rf_regdst;
  logic [31:0] rf_busW;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_write(i_write), .i_fpoint(i_fpoint), .i_rw(i_rw), .i_data(i_data),
    .iss_valid(iss_valid), .iss_rw(iss_rw),
    .f_valid(f_valid), .f_rw(f_rw), .f_data(f_data), .f_ready(f_ready),
    .q_en(q_en), .q_rs(q_rs), .q_rt(q_rt), .q_rd(q_rd), .hazard(hazard),
    .rf_write(rf_write), .rf_fpoint(rf_fpoint), .rf_rd(rf_rd),
    .rf_regdst(rf_regdst), .rf_busW(rf_busW)
  );

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbusy;
  int          n_vec = 0;
  int          n_err = 0;
  bit          do_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; i_write = 1'b0; i_fpoint = 2'd0; i_rw = 5'd0; i_data = 32'd0;
    iss_valid = 1'b0; iss_rw = 5'd0; f_valid = 1'b0; f_rw = 5'd0; f_data = 32'd0;
    q_en = 1'b0; q_rs = 5'd0; q_rt = 5'd0; q_rd = 5'd0;
  endtask

  // Inputs are stable from the preceding negedge; check outputs, advance the
  // model by one posedge, then return at the next negedge.
  task automatic cycle();
    logic        e_write, e_ready, e_haz, pop, byp;
    logic [1:0]  e_fp;
    logic [4:0]  e_rd;
    logic [31:0] e_bus;
    #1;
    e_ready = (mq.size() != DEPTH);
    pop = 1'b0; byp = 1'b0;
    e_write = 1'b0; e_fp = 2'd0; e_rd = 5'd0; e_bus = 32'd0;
    if (i_write) begin
      e_write = 1'b1; e_fp = i_fpoint; e_rd = i_rw; e_bus = i_data;
    end else if (mq.size() > 0) begin
      e_write = 1'b1; e_fp = 2'd3; e_rd = mq[0].rw; e_bus = mq[0].data; pop = 1'b1;
    end else if (f_valid) begin
      e_write = 1'b1; e_fp = 2'd3; e_rd = f_rw; e_bus = f_data; byp = 1'b1;
    end
    e_haz = q_en && (mbusy[q_rs] || mbusy[q_rt] || mbusy[q_rd]);
    if (do_chk) begin
      chk("f_ready",   {31'd0, f_ready},   {31'd0, e_ready});
      chk("hazard",    {31'd0, hazard},    {31'd0, e_haz});
      chk("rf_write",  {31'd0, rf_write},  {31'd0, e_write});
      chk("rf_fpoint", {30'd0, rf_fpoint}, {30'd0, e_fp});
      chk("rf_rd",     {27'd0, rf_rd},     {27'd0, e_rd});
      chk("rf_busW",   rf_busW,            e_bus);
      chk("rf_regdst", {31'd0, rf_regdst}, 32'd1);
    end
    if (reset) begin
      mq.delete();
      mbusy = 32'd0;
    end else begin
      if (pop) begin
        mbusy[e_rd] = 1'b0;
        mq.delete(0);
      end
      if (byp) mbusy[f_rw] = 1'b0;
      if (f_valid && e_ready && !byp) mq.push_back({f_rw, f_data});
      if (iss_valid) mbusy[iss_rw] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    bit held;
    int pct;
    mbusy = 32'd0;
    idle();
    reset = 1'b1;
    cycle();
    do_chk = 1'b1;
    cycle();
    idle();

    // bypass with scoreboard clear
    iss_valid = 1'b1; iss_rw = 5'd4;
    cycle();
    idle(); q_en = 1'b1; q_rs = 5'd4;
    f_valid = 1'b1; f_rw = 5'd4; f_data = 32'h3F80_0000;
    #1;
    chk("byp_hazard", {31'd0, hazard}, 32'd1);
    chk("byp_rd", {27'd0, rf_rd}, 32'd4);
    chk("byp_fp", {30'd0, rf_fpoint}, 32'd3);
    cycle();
    idle(); q_en = 1'b1; q_rs = 5'd4;
    #1;
    chk("byp_clear", {31'd0, hazard}, 32'd0);
    chk("byp_nopush", {31'd0, rf_write}, 32'd0);
    cycle();

    // integer vs FP conflict
    i_write = 1'b1; i_rw = 5'd8; i_data = 32'h11;
    f_valid = 1'b1; f_rw = 5'd2; f_data = 32'h22;
    #1 chk("conf_int", {27'd0, rf_rd}, 32'd8);
    cycle();
    idle();
    #1 chk("conf_fp", {27'd0, rf_rd}, 32'd2);
    cycle();
    #1 chk("conf_empty", {31'd0, rf_write}, 32'd0);
    cycle();

    // fill with i_write held, FP source holds the rejected result
    for (int k = 0; k < 4; k++) begin
      i_write = 1'b1; i_rw = 5'(10 + k); i_data = 32'(k);
      f_valid = 1'b1; f_rw = (k < 2) ? 5'(k + 1) : 5'd3; f_data = (k < 2) ? 32'(100 + k) : 32'd102;
      #1;
      if (k >= 2) chk("full_ready", {31'd0, f_ready}, 32'd0);
      cycle();
    end
    i_write = 1'b0;
    #1 chk("drain1", {27'd0, rf_rd}, 32'd1);
    cycle();
    #1 chk("drain2", {27'd0, rf_rd}, 32'd2);
    chk("drain2_ready", {31'd0, f_ready}, 32'd1);
    cycle();
    idle();
    #1 chk("drain3", {27'd0, rf_rd}, 32'd3);
    cycle();
    cycle();

    // same-cycle set/clear of register 6
    iss_valid = 1'b1; iss_rw = 5'd6;
    cycle();
    idle(); iss_valid = 1'b1; iss_rw = 5'd6; f_valid = 1'b1; f_rw = 5'd6; f_data = 32'h6;
    cycle();
    idle(); q_en = 1'b1; q_rs = 5'd6;
    #1 chk("setwins", {31'd0, hazard}, 32'd1);
    f_valid = 1'b1; f_rw = 5'd6;
    cycle();
    idle(); q_en = 1'b1; q_rd = 5'd6;
    #1 chk("sb_clear", {31'd0, hazard}, 32'd0);
    cycle();

    // reset mid-operation
    iss_valid = 1'b1; iss_rw = 5'd3;
    cycle();
    idle(); i_write = 1'b1; f_valid = 1'b1; f_rw = 5'd5;
    cycle();
    f_rw = 5'd7;
    cycle();
    idle(); reset = 1'b1; f_valid = 1'b1; f_rw = 5'd9;
    cycle();
    idle(); q_en = 1'b1; q_rs = 5'd3;
    #1;
    chk("rst_ready", {31'd0, f_ready}, 32'd1);
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_nostale", {31'd0, rf_write}, 32'd0);
    cycle();

    // random traffic; the FP source holds any result it could not hand over
    held = 1'b0;
    for (int i = 0; i < 800; i++) begin
      pct = ((i / 50) % 2) ? 85 : 30;
      reset     = ($urandom_range(0, 199) == 0);
      i_write   = ($urandom_range(0, 99) < pct);
      i_fpoint  = 2'($urandom_range(0, 3));
      i_rw      = 5'($urandom);
      i_data    = $urandom;
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_rw    = 5'($urandom_range(0, 7));
      q_en      = $urandom_range(0, 1) == 1;
      q_rs      = 5'($urandom_range(0, 7));
      q_rt      = 5'($urandom_range(0, 7));
      q_rd      = 5'($urandom_range(0, 7));
      if (!held) begin
        f_valid = ($urandom_range(0, 99) < 60);
        f_rw    = 5'($urandom_range(0, 7));
        f_data  = $urandom;
      end
      held = f_valid && !reset &&
             !((!i_write && mq.size() == 0) || (mq.size() != DEPTH));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
